// File: rtl/redmule_mx_pkg.sv
// Shared constants and types for the MX (E4M3 + E8M0) to FP16 decoder.
package redmule_mx_pkg;

  // Field layout of the narrow input and wide output formats
  localparam int E4M3_EXP_W = 4;
  localparam int E4M3_MAN_W = 3;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  // Exponent biases
  localparam int E4M3_BIAS = 7;
  localparam int FP16_BIAS = 15;
  localparam int E8M0_BIAS = 127;

  // Largest finite FP16 biased exponent
  localparam int FP16_EXP_MAX = 30;

  // Special encodings
  localparam logic [7:0]  E8M0_NAN    = 8'hFF;
  localparam logic [6:0]  FP8_NAN_MAG = 7'h7F;
  localparam logic [15:0] FP16_QNAN   = 16'h7E00;
  localparam logic [15:0] FP16_INF    = 16'h7C00;

  // Decoder FSM
  typedef enum logic [0:0] {
    MX_IDLE = 1'b0,
    MX_SEND = 1'b1
  } mx_state_e;

endpackage

// File: rtl/redmule_mx_fp8_to_fp16.sv
// Single-element E4M3 -> FP16 converter, scaled by an E8M0 shared exponent.
// Purely combinational; FP16 subnormal results are flushed to signed zero.
module redmule_mx_fp8_to_fp16
  import redmule_mx_pkg::*;
(
  input  logic [7:0]  fp8,
  input  logic [7:0]  exp,
  output logic [15:0] fp16
);

  // Combined bias adjustment: -E4M3 bias + FP16 bias - E8M0 bias
  localparam logic signed [10:0] EXP_OFS = 11'(FP16_BIAS - E4M3_BIAS - E8M0_BIAS);

  logic                            sign;
  logic [E4M3_EXP_W-1:0]           e8;
  logic [E4M3_MAN_W-1:0]           man;
  logic [E4M3_MAN_W-1:0]           frac;
  logic signed [10:0]              e8_eff;
  logic signed [10:0]              res_e;
  logic                            is_nan;
  logic                            is_zero;

  // Decode fields, normalise FP8 subnormals, rebias, then resolve specials
  always_comb begin
    sign    = fp8[7];
    e8      = fp8[6:3];
    man     = fp8[2:0];
    is_nan  = (fp8[6:0] == FP8_NAN_MAG) || (exp == E8M0_NAN);
    is_zero = (e8 == '0) && (man == '0);
    e8_eff  = {7'b0, e8};
    frac    = man;
    // Subnormal: value = man * 2^-9; move the leading one into the hidden bit
    if (e8 == '0) begin
      if (man[2]) begin
        e8_eff = 11'sd0;
        frac   = {man[1:0], 1'b0};
      end else if (man[1]) begin
        e8_eff = -11'sd1;
        frac   = {man[0], 2'b0};
      end else begin
        e8_eff = -11'sd2;
        frac   = 3'b0;
      end
    end
    res_e = e8_eff + EXP_OFS + $signed({3'b0, exp});

    if (is_nan) begin
      fp16 = FP16_QNAN;
    end else if (is_zero) begin
      fp16 = {sign, 15'b0};
    end else if (res_e > 11'(FP16_EXP_MAX)) begin
      fp16 = {sign, FP16_INF[14:0]};
    end else if (res_e < 11'sd1) begin
      fp16 = {sign, 15'b0};
    end else begin
      fp16 = {sign, res_e[FP16_EXP_W-1:0], frac, {(FP16_MAN_W-E4M3_MAN_W){1'b0}}};
    end
  end

endmodule

// File: rtl/redmule_mx_decoder_w.sv
// MX block decoder: captures one FP8 value block plus its per-group E8M0
// exponents, then streams NUM_GROUPS beats of NUM_LANES FP16 elements.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The two input channels are joined: a block is taken only when both
// valids are high together while idle. Output valid/data hold steady until
// fp16_ready_i is seen high.
module redmule_mx_decoder_w
  import redmule_mx_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int BITW      = 16,
  parameter int NUM_LANES = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mx_val_valid_i,
  output logic                      mx_val_ready_o,
  input  logic [DATA_W-1:0]         mx_val_data_i,
  input  logic                      mx_exp_valid_i,
  output logic                      mx_exp_ready_o,
  input  logic [NUM_LANES*8-1:0]    mx_exp_data_i,
  output logic                      fp16_valid_o,
  input  logic                      fp16_ready_i,
  output logic [NUM_LANES*BITW-1:0] fp16_data_o
);

  localparam int NUM_ELEMS  = DATA_W / 8;
  localparam int NUM_GROUPS = NUM_ELEMS / NUM_LANES;
  localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int GRP_BITS   = NUM_LANES * 8;
  localparam int EXP_BITS   = NUM_LANES * 8;

  // Reject configurations the datapath cannot represent
  if ((NUM_ELEMS % NUM_LANES) != 0 || BITW != 16 || NUM_GROUPS > NUM_LANES) begin : g_bad_cfg
    $error("redmule_mx_decoder_w: illegal DATA_W/NUM_LANES/BITW combination");
  end

  mx_state_e           state_q, state_d;
  logic [GW-1:0]       grp_q, grp_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [EXP_BITS-1:0] exp_q, exp_d;

  logic [GRP_BITS-1:0]         grp_val;
  logic [7:0]                  grp_exp;
  logic [NUM_LANES*BITW-1:0]   conv_data;

  // Next-state: join the two input channels, then walk the groups under backpressure
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    val_d   = val_q;
    exp_d   = exp_q;
    case (state_q)
      MX_IDLE: begin
        if (mx_val_valid_i && mx_exp_valid_i) begin
          val_d   = mx_val_data_i;
          exp_d   = mx_exp_data_i;
          grp_d   = '0;
          state_d = MX_SEND;
        end
      end
      MX_SEND: begin
        if (fp16_ready_i) begin
          if (grp_q == GW'(NUM_GROUPS - 1)) begin
            grp_d   = '0;
            state_d = MX_IDLE;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
      end
      default: state_d = MX_IDLE;
    endcase
  end

  // State and captured block registers; reset clears everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MX_IDLE;
      grp_q   <= '0;
      val_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      val_q   <= val_d;
      exp_q   <= exp_d;
    end
  end

  // Select the current group's elements and shared exponent
  always_comb begin
    grp_val = '0;
    grp_exp = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (grp_q == GW'(g)) begin
        grp_val = val_q[g*GRP_BITS +: GRP_BITS];
        grp_exp = exp_q[g*8 +: 8];
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    redmule_mx_fp8_to_fp16 u_conv (
      .fp8  (grp_val[l*8 +: 8]),
      .exp  (grp_exp),
      .fp16 (conv_data[l*BITW +: BITW])
    );
  end

  assign mx_val_ready_o = (state_q == MX_IDLE);
  assign mx_exp_ready_o = (state_q == MX_IDLE);
  assign fp16_valid_o   = (state_q == MX_SEND);
  assign fp16_data_o    = (state_q == MX_SEND) ? conv_data : '0;

endmodule

// File: tb/tb_redmule_mx_decoder_w.sv
// Directed bench for redmule_mx_decoder_w (default parameters).
module tb_redmule_mx_decoder_w;

  localparam int DATA_W    = 256;
  localparam int NUM_LANES = 8;
  localparam int BITW      = 16;

  logic                      clk;
  logic                      rst;
  logic                      val_valid;
  logic                      val_ready;
  logic [DATA_W-1:0]         val_data;
  logic                      exp_valid;
  logic                      exp_ready;
  logic [NUM_LANES*8-1:0]    exp_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_LANES*BITW-1:0] out_data;

  int errors = 0;
  int checks = 0;

  // Block A: group 0 holds the reference conversion vector at E=120,
  // groups 1..3 are all 0x38 at E=124/128/132. Upper exponent bytes are junk.
  logic [DATA_W-1:0]      blk_a_val;
  logic [NUM_LANES*8-1:0] blk_a_exp;
  logic [127:0]           beats_a[4];
  // Block B: special values and exponent boundaries
  logic [DATA_W-1:0]      blk_b_val;
  logic [NUM_LANES*8-1:0] blk_b_exp;
  logic [127:0]           beats_b[4];

  redmule_mx_decoder_w #(
    .DATA_W    (DATA_W),
    .BITW      (BITW),
    .NUM_LANES (NUM_LANES)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mx_val_valid_i (val_valid),
    .mx_val_ready_o (val_ready),
    .mx_val_data_i  (val_data),
    .mx_exp_valid_i (exp_valid),
    .mx_exp_ready_o (exp_ready),
    .mx_exp_data_i  (exp_data),
    .fp16_valid_o   (out_valid),
    .fp16_ready_i   (out_ready),
    .fp16_data_o    (out_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a block on both channels for one edge; returns at the negedge
  // where the first beat should be visible. Inputs are scrambled afterwards.
  task automatic accept_block(input logic [DATA_W-1:0] v, input logic [NUM_LANES*8-1:0] e);
    val_valid = 1'b1;
    exp_valid = 1'b1;
    val_data  = v;
    exp_data  = e;
    @(negedge clk);
    val_valid = 1'b0;
    exp_valid = 1'b0;
    val_data  = {8{$urandom()}};
    exp_data  = {2{$urandom()}};
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    val_valid = 1'b1;
    exp_valid = 1'b1;
    val_data  = blk_a_val;
    exp_data  = blk_a_exp;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    val_valid = 1'b0;
    exp_valid = 1'b0;
    rst       = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (val_ready !== 1'b1 || exp_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b%b exp=11", val_ready, exp_ready);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_block_stream();
    out_ready = 1'b1;
    accept_block(blk_a_val, blk_a_exp);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== beats_a[b]) begin
        errors++; $display("FAIL stream_beat%0d got v=%b d=%h exp v=1 d=%h", b, out_valid, out_data, beats_a[b]);
      end
      checks++;
      if (val_ready !== 1'b0 || exp_ready !== 1'b0) begin
        errors++; $display("FAIL stream_ready%0d got=%b%b exp=00", b, val_ready, exp_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || val_ready !== 1'b1 || exp_ready !== 1'b1) begin
      errors++; $display("FAIL stream_end got v=%b r=%b%b exp v=0 r=11", out_valid, val_ready, exp_ready);
    end
  endtask

  task automatic test_edge_cases();
    out_ready = 1'b1;
    accept_block(blk_b_val, blk_b_exp);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== beats_b[b]) begin
        errors++; $display("FAIL edge_beat%0d got v=%b d=%h exp v=1 d=%h", b, out_valid, out_data, beats_b[b]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL edge_end got v=%b exp v=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int beat;
    beat = 0;
    out_ready = 1'b0;
    accept_block(blk_a_val, blk_a_exp);
    for (int cyc = 0; cyc < 20 && beat < 4; cyc++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== beats_a[beat]) begin
        errors++; $display("FAIL bp_beat%0d_cyc%0d got v=%b d=%h exp v=1 d=%h", beat, cyc, out_valid, out_data, beats_a[beat]);
      end
      checks++;
      if (val_ready !== 1'b0 || exp_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready_cyc%0d got=%b%b exp=00", cyc, val_ready, exp_ready);
      end
      out_ready = (cyc % 2 == 1);
      if (out_ready) beat++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (beat != 4) begin
      errors++; $display("FAIL bp_timeout got beats=%0d exp=4", beat);
    end
    checks++;
    if (out_valid !== 1'b0 || val_ready !== 1'b1) begin
      errors++; $display("FAIL bp_end got v=%b r=%b exp v=0 r=1", out_valid, val_ready);
    end
  endtask

  task automatic test_lone_valid();
    out_ready = 1'b1;
    val_valid = 1'b1;
    exp_valid = 1'b0;
    val_data  = blk_a_val;
    exp_data  = blk_a_exp;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || val_ready !== 1'b1) begin
        errors++; $display("FAIL lone_val_cyc%0d got v=%b r=%b exp v=0 r=1", c, out_valid, val_ready);
      end
    end
    val_valid = 1'b0;
    exp_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL lone_exp_cyc%0d got v=%b exp v=0", c, out_valid);
      end
    end
    val_valid = 1'b1;
    @(negedge clk);
    val_valid = 1'b0;
    exp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== beats_a[0]) begin
      errors++; $display("FAIL lone_first got v=%b d=%h exp v=1 d=%h", out_valid, out_data, beats_a[0]);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL lone_drain got v=%b exp v=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    // Valids held high: accept, 4 beats, one idle cycle, accept again
    out_ready = 1'b1;
    val_valid = 1'b1;
    exp_valid = 1'b1;
    val_data  = blk_a_val;
    exp_data  = blk_a_exp;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== beats_a[b]) begin
        errors++; $display("FAIL b2b_beat%0d got v=%b d=%h exp v=1 d=%h", b, out_valid, out_data, beats_a[b]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || val_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got v=%b r=%b exp v=0 r=1", out_valid, val_ready);
    end
    val_data = blk_b_val;
    exp_data = blk_b_exp;
    @(negedge clk);
    val_valid = 1'b0;
    exp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== beats_b[0]) begin
      errors++; $display("FAIL b2b_second got v=%b d=%h exp v=1 d=%h", out_valid, out_data, beats_b[0]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_send();
    out_ready = 1'b1;
    accept_block(blk_a_val, blk_a_exp);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== beats_a[1]) begin
      errors++; $display("FAIL rstmid_beat1 got v=%b d=%h exp v=1 d=%h", out_valid, out_data, beats_a[1]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || val_ready !== 1'b1 || out_data !== '0) begin
      errors++; $display("FAIL rstmid_idle got v=%b r=%b d=%h exp v=0 r=1 d=0", out_valid, val_ready, out_data);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_nobeat got v=%b exp v=0", out_valid);
    end
    accept_block(blk_b_val, blk_b_exp);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== beats_b[b]) begin
        errors++; $display("FAIL rstmid_new%0d got v=%b d=%h exp v=1 d=%h", b, out_valid, out_data, beats_b[b]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    blk_a_val = {{24{8'h38}}, 64'h34_44_00_30_B8_40_3C_38};
    blk_a_exp = 64'hFFFFFFFF_84_80_7C_78;
    beats_a[0] = 128'h1E00_2600_0000_1C00_A000_2400_2200_2000;
    beats_a[1] = {8{16'h3000}};
    beats_a[2] = {8{16'h4000}};
    beats_a[3] = {8{16'h5000}};

    blk_b_val = {64'h00_00_00_00_7F_78_B8_38,
                 64'h00_01_50_48_40_38_F8_78,
                 {8{8'h38}},
                 64'h00_07_02_38_80_FF_01_7F};
    blk_b_exp = 64'h00000000_64_8C_FF_7F;
    beats_b[0] = 128'h0000_2300_1C00_3C00_8000_7E00_1800_7E00;
    beats_b[1] = {8{16'h7E00}};
    beats_b[2] = 128'h0000_4C00_7C00_7800_7400_7000_FC00_7C00;
    beats_b[3] = 128'h0000_0000_0000_0000_7E00_0000_8000_0000;

    rst       = 1'b1;
    val_valid = 1'b0;
    exp_valid = 1'b0;
    val_data  = '0;
    exp_data  = '0;
    out_ready = 1'b1;
    @(negedge clk);

    test_reset();
    test_block_stream();
    test_edge_cases();
    test_backpressure();
    test_lone_valid();
    test_back_to_back();
    test_reset_mid_send();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
